// File: rtl/bounce_pkg.sv
// Shared types and constants for the switch-bounce emulator.
// Holds the FSM state enum, LFSR geometry and the saturating counter helper.
package bounce_pkg;

   typedef enum logic {IDLE, BOUNCE} state_t;

   localparam int LFSR_W = 16;
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
   localparam int CNT_W = 8;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/bounce_emulator_lfsr16.sv
// 16-bit Galois LFSR that free-runs whenever reset is low.
// A zero seed would lock the register, so it is replaced by 1.
module lfsr16
   import bounce_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic [LFSR_W-1:0] seed,
   output logic [LFSR_W-1:0] value
);

   logic [LFSR_W-1:0] lfsr_reg;
   logic [LFSR_W-1:0] lfsr_next;

   // Shift right; the bit falling out of position 0 is fed back into the tap positions.
   generate
      for (genvar gi = 0; gi < LFSR_W; gi++) begin : g_tap
         if (gi == LFSR_W - 1) begin : g_top
            assign lfsr_next[gi] = LFSR_TAPS[gi] & lfsr_reg[0];
         end else begin : g_mid
            assign lfsr_next[gi] = lfsr_reg[gi+1] ^ (LFSR_TAPS[gi] & lfsr_reg[0]);
         end
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (reset) begin
         lfsr_reg <= (seed == '0) ? LFSR_W'(1) : seed;
      end else begin
         lfsr_reg <= lfsr_next;
      end
   end

   assign value = lfsr_reg;

endmodule

// File: rtl/bounce_emulator.sv
// Switch-bounce emulator: turns a clean level into a deterministic pseudo-random
// burst of glitches lasting BOUNCE_CYCLES clocks after every accepted change.
module bounce_emulator
   import bounce_pkg::*;
#(
   parameter int          BOUNCE_CYCLES = 25000,
   parameter int          MAX_GLITCH    = 511,
   parameter logic [15:0] SEED          = 16'hACE1
)(
   input  logic             clock,
   input  logic             reset,
   input  logic             cleanIn,
   input  logic             enable,
   output logic             bouncyOut,
   output logic             bouncing,
   output logic [CNT_W-1:0] toggleCount
);

   localparam int WIN_W = 16;
   localparam logic [WIN_W-1:0]  WIN_LOAD    = WIN_W'(BOUNCE_CYCLES - 1);
   localparam logic [LFSR_W-1:0] GLITCH_MASK = LFSR_W'(MAX_GLITCH);

   logic [1:0]        sync_reg;
   logic              in_sync;
   state_t            state_reg;
   logic              stable_reg;
   logic              target_reg;
   logic              out_reg;
   logic              bouncing_reg;
   logic [CNT_W-1:0]  count_reg;
   logic [WIN_W-1:0]  win_cnt_reg;
   logic [LFSR_W-1:0] seg_cnt_reg;
   logic [LFSR_W-1:0] lfsr_value;

   lfsr16 u_lfsr (
      .clock (clock),
      .reset (reset),
      .seed  (SEED),
      .value (lfsr_value)
   );

   assign in_sync = sync_reg[1];

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_reg     <= '0;
         state_reg    <= IDLE;
         stable_reg   <= 1'b0;
         target_reg   <= 1'b0;
         out_reg      <= 1'b0;
         bouncing_reg <= 1'b0;
         count_reg    <= '0;
         win_cnt_reg  <= '0;
         seg_cnt_reg  <= '0;
      end else begin
         sync_reg <= {sync_reg[0], cleanIn};
         case (state_reg)
            IDLE: begin
               if (in_sync != stable_reg) begin
                  if (enable) begin
                     target_reg   <= in_sync;
                     out_reg      <= ~out_reg;
                     count_reg    <= CNT_W'(1);
                     win_cnt_reg  <= WIN_LOAD;
                     seg_cnt_reg  <= lfsr_value & GLITCH_MASK;
                     bouncing_reg <= 1'b1;
                     state_reg    <= BOUNCE;
                  end else begin
                     stable_reg <= in_sync;
                     out_reg    <= in_sync;
                  end
               end
            end
            BOUNCE: begin
               win_cnt_reg <= win_cnt_reg - 1'b1;
               // Last window cycle forces the settled level; this counts only if it flips the output.
               if (win_cnt_reg == WIN_W'(1)) begin
                  out_reg      <= target_reg;
                  stable_reg   <= target_reg;
                  bouncing_reg <= 1'b0;
                  state_reg    <= IDLE;
                  if (out_reg != target_reg) begin
                     count_reg <= sat_inc(count_reg);
                  end
               end else if (seg_cnt_reg == '0) begin
                  out_reg     <= ~out_reg;
                  seg_cnt_reg <= lfsr_value & GLITCH_MASK;
                  count_reg   <= sat_inc(count_reg);
               end else begin
                  seg_cnt_reg <= seg_cnt_reg - 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bouncyOut   = out_reg;
   assign bouncing    = bouncing_reg;
   assign toggleCount = count_reg;

endmodule
